shift_reg_sequencer: RTL and testbench
======================================

# shift_reg_sequencer

Command-driven controller that sequences the 4-bit universal shift register: it accepts a load-and-shift command over a valid/ready handshake, drives the register's ENB/DIR/S_IN/MODO/D pins to parallel-load a word and shift it a programmed number of times, and collects every bit that leaves through S_OUT. It sits between a requester (test sequencer or upstream datapath) and one shift-register instance, and owns that register's control pins exclusively.

## Interface
Parameters:
- MAX_CNT, 7, largest legal shift count; sets CMD_CNT width (3) and SER_BITS width (MAX_CNT+1 = 8).

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- CMD_VALID  in  1  requester has a command.
- CMD_READY  out  1  sequencer idle; command accepted on edge where VALID&READY.
- CMD_D  in  4  word to parallel-load.
- CMD_DIR  in  1  shift direction (`LOW = left, toward Q[3]).
- CMD_SIN  in  1  serial fill bit for every shift.
- CMD_CNT  in  3  number of shifts, 0..7.
- ABORT  in  1  cancel in-flight command.
- ENB, DIR, S_IN  out  1 each  shift-register control.
- MODO  out  2  shift-register mode (`PARA_LOAD / `SHIFT).
- D  out  4  shift-register parallel input.
- Q  in  4  shift-register state.
- S_OUT  in  1  bit that leaves on the next shift edge (Q[3] left, Q[0] right).
- DONE  out  1  one-cycle completion pulse.
- Q_FINAL  out  4  register contents after last shift.
- SER_BITS  out  8  shifted-out bits, first bit in [0]; unused upper bits 0.

## Operation
- States: IDLE, LOAD, SHIFT, CAPTURE.
- IDLE: ENB = !`ENABLE, MODO = `PARA_LOAD. CMD_READY = (state==IDLE) & RST_N. On accept, latch D, DIR, SIN, CNT; clear SER_BITS and bit index → LOAD.
- LOAD (1 cycle): ENB = `ENABLE, MODO = `PARA_LOAD, D = latched word. → SHIFT if CNT>0, else CAPTURE.
- SHIFT (CNT cycles): ENB = `ENABLE, MODO = `SHIFT, DIR/S_IN from latch. Each edge: SER_BITS[idx] <= S_OUT, idx++, remaining--. Last shift → CAPTURE.
- CAPTURE (1 cycle): ENB = !`ENABLE; Q_FINAL <= Q → IDLE with DONE=1 for exactly that next cycle.
- Q_FINAL/SER_BITS hold until the next accept.
- ABORT in LOAD/SHIFT/CAPTURE: ENB disabled next cycle, → IDLE, no DONE, Q_FINAL unchanged, SER_BITS keep partial bits. ABORT in IDLE ignored; ABORT and accept in the same cycle: accept wins.
- CMD_* ignored while not READY.

## Timing
- Accept at edge E0. LOAD is cycle 1, shifts cycles 2..CNT+1, CAPTURE cycle CNT+2, DONE high cycle CNT+3.
- CMD_READY is high in the DONE cycle; a new command may be accepted there (back-to-back period = CNT+3 cycles).
- Reset (RST_N low at an edge, any state): state IDLE, ENB = !`ENABLE, MODO = `PARA_LOAD, DIR = `LOW, S_IN = `LOW, D = 0, DONE = 0, Q_FINAL = 0, SER_BITS = 0; CMD_READY = 0 while RST_N low.
- All outputs except CMD_READY are registered or decoded only from state/latch registers; none depend combinationally on CMD_*.

## Structure
- Shared header: `LOW, `ENABLE, `PARA_LOAD, `SHIFT, and new state encodings `SEQ_IDLE/`SEQ_LOAD/`SEQ_SHIFT/`SEQ_CAPT; MODO encodings stay single-sourced there.
- No sub-module; a separate top-level test wrapper instantiates the sequencer plus the shift register.

## Test plan
- D=0001, left, SIN=0, CNT=3 → Q 0010/0100/1000, DONE cycle 6, Q_FINAL=1000, SER_BITS=8'h00.
- D=0011, left, SIN=1, CNT=4 → Q_FINAL=1111, SER_BITS=8'b0000_1100.
- D=1011, right, SIN=0, CNT=2 → Q_FINAL=0010, SER_BITS=8'b0000_0011.
- D=0110, CNT=0 → LOAD then CAPTURE, DONE cycle 3, Q_FINAL=0110, SER_BITS=0; then CMD_VALID held high → second command accepted in the DONE cycle.
- CNT=7 with ABORT in second shift cycle → ENB disabled next cycle, no DONE, READY back high; same with RST_N low mid-SHIFT → all outputs at reset values.

Source files
------------

// File: rtl/shift_reg_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// shift_reg_sequencer_pkg
//   Shared encodings for the 4-bit universal shift register control pins and
//   the sequencer state machine. MODO encodings live only here, so the
//   sequencer and anything modelling the register agree on them.
// ---------------------------------------------------------------------------
package shift_reg_sequencer_pkg;

  // Logic level used for DIR (left shift) and the idle value of S_IN.
  localparam logic LOW    = 1'b0;
  // ENB value that lets the shift register act on a clock edge.
  localparam logic ENABLE = 1'b1;

  // Shift-register MODO encodings.
  localparam logic [1:0] PARA_LOAD = 2'b00;
  localparam logic [1:0] SHIFT     = 2'b01;

  // Sequencer states.
  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_LOAD  = 2'd1,
    SEQ_SHIFT = 2'd2,
    SEQ_CAPT  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/shift_reg_sequencer.sv
// ---------------------------------------------------------------------------
// shift_reg_sequencer
//   Accepts a load-and-shift command over a valid/ready handshake, drives a
//   4-bit universal shift register to parallel-load a word and shift it
//   CMD_CNT times, records every bit leaving through S_OUT, and reports the
//   final register contents with a one-cycle DONE pulse.
//
// Ports
//   CLK, RST_N        clock, synchronous active-low reset
//   CMD_VALID/READY   command handshake (accept on VALID & READY)
//   CMD_D/DIR/SIN/CNT word, direction, serial fill bit, shift count
//   ABORT             cancel the command in flight
//   ENB, DIR, S_IN,
//   MODO, D           shift-register control pins (owned exclusively here)
//   Q, S_OUT          shift-register state and outgoing serial bit
//   DONE              one-cycle completion pulse
//   Q_FINAL           register contents after the last shift
//   SER_BITS          shifted-out bits, first bit in [0]
// ---------------------------------------------------------------------------
module shift_reg_sequencer
  import shift_reg_sequencer_pkg::*;
#(
  parameter  int MAX_CNT = 7,
  localparam int CNT_W   = $clog2(MAX_CNT + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [3:0]       CMD_D,
  input  logic             CMD_DIR,
  input  logic             CMD_SIN,
  input  logic [CNT_W-1:0] CMD_CNT,
  input  logic             ABORT,
  output logic             ENB,
  output logic             DIR,
  output logic             S_IN,
  output logic [1:0]       MODO,
  output logic [3:0]       D,
  input  logic [3:0]       Q,
  input  logic             S_OUT,
  output logic             DONE,
  output logic [3:0]       Q_FINAL,
  output logic [MAX_CNT:0] SER_BITS
);

  seq_state_t state_reg, state_next;

  logic [3:0]         d_reg;
  logic               dir_reg;
  logic               sin_reg;
  logic [CNT_W-1:0]   rem_reg;     // shifts still to perform
  logic [CNT_W-1:0]   idx_reg;     // next SER_BITS position to fill
  logic [3:0]         q_final_reg;
  logic               done_reg;
  logic [MAX_CNT-1:0] ser_bits_reg;

  logic accept;
  logic shift_en;
  logic capt_en;
  logic done_next;

  // READY is forced low while reset is asserted so nothing is accepted on
  // the edge that is clearing the state.
  assign CMD_READY = (state_reg == SEQ_IDLE) & RST_N;
  assign accept    = CMD_VALID & CMD_READY;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg <= SEQ_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state plus pin decode. ENB/MODO depend on state only; the register
  // acts on the same edge that moves the sequencer to its next state.
  always_comb begin
    state_next = state_reg;
    ENB        = !ENABLE;
    MODO       = PARA_LOAD;
    shift_en   = 1'b0;
    capt_en    = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      SEQ_IDLE: begin
        if (accept) begin
          state_next = SEQ_LOAD;
        end
      end
      SEQ_LOAD: begin
        ENB = ENABLE;
        if (ABORT) begin
          state_next = SEQ_IDLE;
        end else if (rem_reg != '0) begin
          state_next = SEQ_SHIFT;
        end else begin
          state_next = SEQ_CAPT;
        end
      end
      SEQ_SHIFT: begin
        ENB  = ENABLE;
        MODO = SHIFT;
        // The register shifts on this edge even if ABORT is high, so the
        // departing bit is still recorded.
        shift_en = 1'b1;
        if (ABORT) begin
          state_next = SEQ_IDLE;
        end else if (rem_reg == CNT_W'(1)) begin
          state_next = SEQ_CAPT;
        end
      end
      SEQ_CAPT: begin
        state_next = SEQ_IDLE;
        if (!ABORT) begin
          capt_en   = 1'b1;
          done_next = 1'b1;
        end
      end
      default: begin
        state_next = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      d_reg       <= 4'd0;
      dir_reg     <= LOW;
      sin_reg     <= LOW;
      rem_reg     <= '0;
      idx_reg     <= '0;
      q_final_reg <= 4'd0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= done_next;
      if (accept) begin
        d_reg   <= CMD_D;
        dir_reg <= CMD_DIR;
        sin_reg <= CMD_SIN;
        rem_reg <= CMD_CNT;
        idx_reg <= '0;
      end else if (shift_en) begin
        rem_reg <= rem_reg - CNT_W'(1);
        idx_reg <= idx_reg + CNT_W'(1);
      end
      if (capt_en) begin
        q_final_reg <= Q;
      end
    end
  end

  // One capture flop per serial position; a count of MAX_CNT shifts fills
  // positions 0..MAX_CNT-1, so the top SER_BITS bit is never written.
  for (genvar gi = 0; gi < MAX_CNT; gi++) begin : g_ser
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        ser_bits_reg[gi] <= 1'b0;
      end else if (accept) begin
        ser_bits_reg[gi] <= 1'b0;
      end else if (shift_en && (idx_reg == CNT_W'(gi))) begin
        ser_bits_reg[gi] <= S_OUT;
      end
    end
  end

  assign DIR      = dir_reg;
  assign S_IN     = sin_reg;
  assign D        = d_reg;
  assign DONE     = done_reg;
  assign Q_FINAL  = q_final_reg;
  assign SER_BITS = {1'b0, ser_bits_reg};

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_sequencer
//   Directed bench for shift_reg_sequencer with a behavioural 4-bit universal
//   shift register attached to its control pins.
// ---------------------------------------------------------------------------
module tb_shift_reg_sequencer;
  import shift_reg_sequencer_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [3:0] CMD_D;
  logic       CMD_DIR;
  logic       CMD_SIN;
  logic [2:0] CMD_CNT;
  logic       ABORT;
  logic       ENB;
  logic       DIR;
  logic       S_IN;
  logic [1:0] MODO;
  logic [3:0] D;
  logic [3:0] Q;
  logic       S_OUT;
  logic       DONE;
  logic [3:0] Q_FINAL;
  logic [7:0] SER_BITS;

  int checks   = 0;
  int failures = 0;
  int q_hist [0:63];

  always #5 CLK = ~CLK;

  shift_reg_sequencer #(.MAX_CNT(7)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_D(CMD_D), .CMD_DIR(CMD_DIR), .CMD_SIN(CMD_SIN), .CMD_CNT(CMD_CNT),
    .ABORT(ABORT),
    .ENB(ENB), .DIR(DIR), .S_IN(S_IN), .MODO(MODO), .D(D),
    .Q(Q), .S_OUT(S_OUT),
    .DONE(DONE), .Q_FINAL(Q_FINAL), .SER_BITS(SER_BITS)
  );

  // Behavioural 4-bit universal shift register.
  logic [3:0] sr_q;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sr_q <= 4'd0;
    end else if (ENB == ENABLE) begin
      if (MODO == PARA_LOAD) begin
        sr_q <= D;
      end else if (MODO == SHIFT) begin
        sr_q <= (DIR == LOW) ? {sr_q[2:0], S_IN} : {S_IN, sr_q[3:1]};
      end
    end
  end
  assign Q     = sr_q;
  assign S_OUT = (DIR == LOW) ? sr_q[3] : sr_q[0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Called at a negedge with the sequencer idle; returns at the negedge of
  // the LOAD cycle (cycle 1).
  task automatic send(input logic [3:0] d, input logic dir, input logic sin,
                      input logic [2:0] cnt, input logic hold, input string tag);
    CMD_D     = d;
    CMD_DIR   = dir;
    CMD_SIN   = sin;
    CMD_CNT   = cnt;
    CMD_VALID = 1'b1;
    chk({tag, "_ready"}, 32'(CMD_READY), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    if (!hold) CMD_VALID = 1'b0;
    chk({tag, "_load_enb"}, 32'(ENB), 32'(ENABLE));
    chk({tag, "_load_modo"}, 32'(MODO), 32'(PARA_LOAD));
    chk({tag, "_load_d"}, 32'(D), 32'(d));
    chk({tag, "_busy"}, 32'(CMD_READY), 32'd0);
  endtask

  // Entered at the cycle-1 negedge; stops at the negedge where DONE is seen
  // (or after a bounded number of cycles) and checks the cycle number.
  task automatic wait_done(input int exp_cyc, input string tag);
    int cyc = 1;
    bool_loop: while (1) begin
      q_hist[cyc] = int'(Q);
      if (cyc == 2 && exp_cyc > 3) chk({tag, "_shift_modo"}, 32'(MODO), 32'(SHIFT));
      if (DONE || cyc >= 40) break;
      @(negedge CLK);
      cyc++;
    end
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0; CMD_VALID = 1'b0; CMD_D = 4'd0; CMD_DIR = 1'b0;
    CMD_SIN = 1'b0; CMD_CNT = 3'd0; ABORT = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_ready", 32'(CMD_READY), 32'd0);
    chk("rst_enb", 32'(ENB), 32'(!ENABLE));
    chk("rst_modo", 32'(MODO), 32'(PARA_LOAD));
    chk("rst_dir", 32'(DIR), 32'(LOW));
    chk("rst_sin", 32'(S_IN), 32'(LOW));
    chk("rst_d", 32'(D), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_qfinal", 32'(Q_FINAL), 32'd0);
    chk("rst_ser", 32'(SER_BITS), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("idle_ready", 32'(CMD_READY), 32'd1);

    // T1: 0001 left, SIN=0, 3 shifts.
    send(4'b0001, 1'b0, 1'b0, 3'd3, 1'b0, "t1");
    wait_done(6, "t1");
    chk("t1_q_c3", 32'(q_hist[3]), 32'b0010);
    chk("t1_q_c4", 32'(q_hist[4]), 32'b0100);
    chk("t1_q_c5", 32'(q_hist[5]), 32'b1000);
    chk("t1_qfinal", 32'(Q_FINAL), 32'b1000);
    chk("t1_ser", 32'(SER_BITS), 32'h00);
    chk("t1_ready_in_done", 32'(CMD_READY), 32'd1);
    @(negedge CLK);
    chk("t1_done_pulse", 32'(DONE), 32'd0);
    chk("t1_qfinal_hold", 32'(Q_FINAL), 32'b1000);

    // T2: 0011 left, SIN=1, 4 shifts.
    send(4'b0011, 1'b0, 1'b1, 3'd4, 1'b0, "t2");
    wait_done(7, "t2");
    chk("t2_qfinal", 32'(Q_FINAL), 32'b1111);
    chk("t2_ser", 32'(SER_BITS), 32'b0000_1100);
    @(negedge CLK);

    // T3: 1011 right, SIN=0, 2 shifts.
    send(4'b1011, 1'b1, 1'b0, 3'd2, 1'b0, "t3");
    wait_done(5, "t3");
    chk("t3_qfinal", 32'(Q_FINAL), 32'b0010);
    chk("t3_ser", 32'(SER_BITS), 32'b0000_0011);
    @(negedge CLK);

    // T4: 0110, zero shifts, VALID held; fields changed while busy must be
    // ignored, then a second command is accepted in the DONE cycle.
    send(4'b0110, 1'b0, 1'b1, 3'd0, 1'b1, "t4");
    CMD_D = 4'b1011; CMD_DIR = 1'b1; CMD_SIN = 1'b0; CMD_CNT = 3'd2;
    wait_done(3, "t4");
    chk("t4_qfinal", 32'(Q_FINAL), 32'b0110);
    chk("t4_ser", 32'(SER_BITS), 32'h00);
    chk("t4_ready_in_done", 32'(CMD_READY), 32'd1);
    send(4'b1011, 1'b1, 1'b0, 3'd2, 1'b0, "t4b");
    wait_done(5, "t4b");
    chk("t4b_qfinal", 32'(Q_FINAL), 32'b0010);
    chk("t4b_ser", 32'(SER_BITS), 32'b0000_0011);
    @(negedge CLK);

    // T5: ABORT together with accept (accept wins), then ABORT in the
    // second shift cycle of a 7-shift command.
    ABORT = 1'b1;
    send(4'b0101, 1'b0, 1'b1, 3'd7, 1'b0, "t5");
    ABORT = 1'b0;
    repeat (2) @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("t5_abort_enb", 32'(ENB), 32'(!ENABLE));
    chk("t5_abort_ready", 32'(CMD_READY), 32'd1);
    chk("t5_abort_qfinal", 32'(Q_FINAL), 32'b0010);
    chk("t5_abort_ser", 32'(SER_BITS), 32'b0000_0010);
    begin
      int pulses = 0;
      for (int i = 0; i < 12; i++) begin
        if (DONE) pulses++;
        @(negedge CLK);
      end
      chk("t5_no_done", 32'(pulses), 32'd0);
    end

    // T6: reset asserted mid-SHIFT.
    send(4'b1001, 1'b1, 1'b1, 3'd7, 1'b0, "t6");
    repeat (2) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("t6_rst_ready", 32'(CMD_READY), 32'd0);
    chk("t6_rst_enb", 32'(ENB), 32'(!ENABLE));
    chk("t6_rst_modo", 32'(MODO), 32'(PARA_LOAD));
    chk("t6_rst_dir", 32'(DIR), 32'(LOW));
    chk("t6_rst_sin", 32'(S_IN), 32'(LOW));
    chk("t6_rst_d", 32'(D), 32'd0);
    chk("t6_rst_done", 32'(DONE), 32'd0);
    chk("t6_rst_qfinal", 32'(Q_FINAL), 32'd0);
    chk("t6_rst_ser", 32'(SER_BITS), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("t6_ready_after", 32'(CMD_READY), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
